// File: rtl/display_mux_controller_if.sv
// rtl/display_mux_controller_if.sv - switch/adder/display signal bundle for display_mux_controller
//
// Purpose: groups the switch inputs, the adder round trip and the
// display-side outputs of the two-digit display sequencer.
// Ports (slave = the controller):
//   s1, s2      switch banks, operand A / operand B sources
//   sum_in      5-bit sum returned from the shared adder
//   add_a/add_b registered adder operands
//   dig_val     nibble to the shared seven-segment decoder
//   en0_n/en1_n active-low digit anode enables
//   led         registered sum display
//   frame_tick  one-cycle pulse at the start of each frame
interface display_mux_controller_if;
  logic [3:0] s1;
  logic [3:0] s2;
  logic [4:0] sum_in;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic [3:0] dig_val;
  logic       en0_n;
  logic       en1_n;
  logic [4:0] led;
  logic       frame_tick;

  modport master (
    output s1, s2, sum_in,
    input  add_a, add_b, dig_val, en0_n, en1_n, led, frame_tick
  );

  modport slave (
    input  s1, s2, sum_in,
    output add_a, add_b, dig_val, en0_n, en1_n, led, frame_tick
  );
endinterface

// File: rtl/display_mux_controller.sv
// rtl/display_mux_controller.sv - two-digit multiplexed display sequencer with shared adder
//
// Purpose: once per frame snapshots s1/s2 into the adder operands, latches
// the returned sum onto led, and time-multiplexes digit 0 (operand A) and
// digit 1 (operand B) with optional blanking gaps between them.
// Frame = LOAD(1) + SHOW0(DWELL) + BLANK01(BLANK) + SHOW1(DWELL) + BLANK10(BLANK).
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    display_mux_controller_if.slave (see interface for signal list)
// All outputs are registered; each state's outputs are loaded on the edge
// on which the state itself executes, so the enable and the matching
// dig_val always change on the same edge.
module display_mux_controller #(
  parameter int DWELL_CYCLES = 24000,
  parameter int BLANK_CYCLES = 240
) (
  input  logic clk,
  input  logic reset,
  display_mux_controller_if.slave bus
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2((CNT_MAX > 2) ? CNT_MAX : 2);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  // With no blanking the blank states are never entered; the value is unused.
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
  localparam bit               NO_BLANK   = (BLANK_CYCLES == 0);

  typedef enum logic [2:0] {
    LOAD    = 3'd0,
    SHOW0   = 3'd1,
    BLANK01 = 3'd2,
    SHOW1   = 3'd3,
    BLANK10 = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic [3:0] add_a_q, add_a_n;
  logic [3:0] add_b_q, add_b_n;
  logic [3:0] dig_q,   dig_n;
  logic [4:0] led_q,   led_n;
  logic       en0_q,   en0_n_d;
  logic       en1_q,   en1_n_d;
  logic       tick_q,  tick_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= LOAD;
      cnt     <= '0;
      add_a_q <= '0;
      add_b_q <= '0;
      dig_q   <= '0;
      led_q   <= '0;
      en0_q   <= 1'b1;
      en1_q   <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      add_a_q <= add_a_n;
      add_b_q <= add_b_n;
      dig_q   <= dig_n;
      led_q   <= led_n;
      en0_q   <= en0_n_d;
      en1_q   <= en1_n_d;
      tick_q  <= tick_n;
    end
  end

  always_comb begin
    // Defaults: stay, count up, hold data registers, both digits dark.
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    add_a_n = add_a_q;
    add_b_n = add_b_q;
    dig_n   = dig_q;
    led_n   = led_q;
    en0_n_d = 1'b1;
    en1_n_d = 1'b1;
    tick_n  = 1'b0;

    case (state)
      LOAD: begin
        // Only point where the switches are sampled; operands (and hence
        // the adder's sum) stay frozen for the rest of the frame.
        add_a_n = bus.s1;
        add_b_n = bus.s2;
        tick_n  = 1'b1;
        cnt_n   = '0;
        state_n = SHOW0;
      end

      SHOW0: begin
        en0_n_d = 1'b0;
        dig_n   = add_a_q;
        // add_a/add_b settled on the LOAD edge, so sum_in is valid here.
        if (cnt == '0) begin
          led_n = bus.sum_in;
        end
        if (cnt == DWELL_LAST) begin
          cnt_n   = '0;
          state_n = NO_BLANK ? SHOW1 : BLANK01;
        end
      end

      BLANK01: begin
        if (cnt == BLANK_LAST) begin
          cnt_n   = '0;
          state_n = SHOW1;
        end
      end

      SHOW1: begin
        en1_n_d = 1'b0;
        dig_n   = add_b_q;
        if (cnt == DWELL_LAST) begin
          cnt_n   = '0;
          state_n = NO_BLANK ? LOAD : BLANK10;
        end
      end

      BLANK10: begin
        if (cnt == BLANK_LAST) begin
          cnt_n   = '0;
          state_n = LOAD;
        end
      end

      default: begin
        cnt_n   = '0;
        state_n = LOAD;
      end
    endcase
  end

  assign bus.add_a      = add_a_q;
  assign bus.add_b      = add_b_q;
  assign bus.dig_val    = dig_q;
  assign bus.led        = led_q;
  assign bus.en0_n      = en0_q;
  assign bus.en1_n      = en1_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_display_mux_controller.sv
// tb/tb_display_mux_controller.sv - self-checking bench for display_mux_controller
module tb_display_mux_controller;

  localparam int DA = 4;
  localparam int BA = 2;
  localparam int PA = 1 + 2*DA + 2*BA;
  localparam int DB = 3;
  localparam int BB = 0;
  localparam int PB = 1 + 2*DB + 2*BB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ra = 1'b1;
  logic rb = 1'b1;
  logic mon_en = 1'b0;

  int checks   = 0;
  int failures = 0;

  display_mux_controller_if busa ();
  display_mux_controller_if busb ();

  // Adder stand-in: the sum the external adder would return.
  assign busa.sum_in = {1'b0, busa.add_a} + {1'b0, busa.add_b};
  assign busb.sum_in = {1'b0, busb.add_a} + {1'b0, busb.add_b};

  display_mux_controller #(.DWELL_CYCLES(DA), .BLANK_CYCLES(BA)) u_a (
    .clk(clk), .reset(ra), .bus(busa.slave)
  );

  display_mux_controller #(.DWELL_CYCLES(DB), .BLANK_CYCLES(BB)) u_b (
    .clk(clk), .reset(rb), .bus(busb.slave)
  );

  typedef struct {
    logic       tick;
    logic       e0;
    logic       e1;
    logic       dchk;
    logic [3:0] dv;
  } exp_t;

  // Expected display outputs at position pos within a frame (pos 0 = LOAD).
  function automatic exp_t frame_model(int pos, int d, int b, logic [3:0] av, logic [3:0] bv);
    exp_t e;
    e.tick = (pos == 0);
    e.e0   = 1'b1;
    e.e1   = 1'b1;
    e.dchk = 1'b0;
    e.dv   = 4'd0;
    if (pos >= 1 && pos <= d) begin
      e.e0 = 1'b0; e.dchk = 1'b1; e.dv = av;
    end else if (pos >= d + b + 1 && pos <= 2*d + b) begin
      e.e1 = 1'b0; e.dchk = 1'b1; e.dv = bv;
    end
    return e;
  endfunction

  // Enable exclusivity on every cycle of both instances.
  always @(negedge clk) begin
    if (mon_en) begin
      checks = checks + 2;
      if (busa.en0_n === 1'b0 && busa.en1_n === 1'b0) begin
        failures++;
        $display("FAIL excl_a t=%0t en0_n=%b en1_n=%b required not both 0", $time, busa.en0_n, busa.en1_n);
      end
      if (busb.en0_n === 1'b0 && busb.en1_n === 1'b0) begin
        failures++;
        $display("FAIL excl_b t=%0t en0_n=%b en1_n=%b required not both 0", $time, busb.en0_n, busb.en1_n);
      end
    end
  end

  task automatic reset_a(input logic [3:0] v1, input logic [3:0] v2);
    ra = 1'b1;
    busa.s1 = v1;
    busa.s2 = v2;
    @(posedge clk);
    @(posedge clk);
    #1;
    ra = 1'b0;
  endtask

  task automatic test_reset();
    ra = 1'b1; rb = 1'b1;
    busa.s1 = 4'($urandom); busa.s2 = 4'($urandom);
    busb.s1 = 4'($urandom); busb.s2 = 4'($urandom);
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busa.add_a, busa.add_b, busa.dig_val, busa.led, busa.en0_n, busa.en1_n, busa.frame_tick} !== {4'd0, 4'd0, 4'd0, 5'd0, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_a got a=%0d b=%0d dig=%0d led=%0d en=%b%b tick=%b required 0 0 0 0 11 0",
               busa.add_a, busa.add_b, busa.dig_val, busa.led, busa.en0_n, busa.en1_n, busa.frame_tick);
    end
    checks++;
    if ({busb.add_a, busb.add_b, busb.dig_val, busb.led, busb.en0_n, busb.en1_n, busb.frame_tick} !== {4'd0, 4'd0, 4'd0, 5'd0, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_b got a=%0d b=%0d dig=%0d led=%0d en=%b%b tick=%b required 0 0 0 0 11 0",
               busb.add_a, busb.add_b, busb.dig_val, busb.led, busb.en0_n, busb.en1_n, busb.frame_tick);
    end
  endtask

  // Frame 1 with s1=3, s2=5, then the next frame_tick at cycle 13.
  task automatic test_basic_frame();
    exp_t e;
    reset_a(4'd3, 4'd5);
    for (int c = 0; c <= PA; c++) begin
      @(posedge clk); #1;
      e = frame_model(c % PA, DA, BA, 4'd3, 4'd5);
      checks++;
      if ({busa.frame_tick, busa.en0_n, busa.en1_n} !== {e.tick, e.e0, e.e1}) begin
        failures++;
        $display("FAIL basic_ctrl cyc=%0d got tick,en0,en1=%b%b%b required %b%b%b",
                 c, busa.frame_tick, busa.en0_n, busa.en1_n, e.tick, e.e0, e.e1);
      end
      if (e.dchk) begin
        checks++;
        if (busa.dig_val !== e.dv) begin
          failures++;
          $display("FAIL basic_dig cyc=%0d got %0d required %0d", c, busa.dig_val, e.dv);
        end
      end
      checks++;
      if (busa.add_a !== 4'd3 || busa.add_b !== 4'd5) begin
        failures++;
        $display("FAIL basic_ops cyc=%0d got %0d,%0d required 3,5", c, busa.add_a, busa.add_b);
      end
      if (c >= 2 && c < PA) begin
        checks++;
        if (busa.led !== 5'd8) begin
          failures++;
          $display("FAIL basic_led cyc=%0d got %0d required 8", c, busa.led);
        end
      end
    end
  endtask

  // s1 goes 3->9 during SHOW1 of frame 1; only frame 2 may see it.
  task automatic test_switch_change();
    exp_t       e;
    logic [3:0] av;
    int         pos;
    reset_a(4'd3, 4'd5);
    for (int c = 0; c < 2*PA; c++) begin
      @(posedge clk); #1;
      pos = c % PA;
      av  = (c < PA) ? 4'd3 : 4'd9;
      e   = frame_model(pos, DA, BA, av, 4'd5);
      checks++;
      if (busa.add_a !== av) begin
        failures++;
        $display("FAIL switch_opa cyc=%0d got %0d required %0d", c, busa.add_a, av);
      end
      if (e.dchk) begin
        checks++;
        if (busa.dig_val !== e.dv) begin
          failures++;
          $display("FAIL switch_dig cyc=%0d got %0d required %0d", c, busa.dig_val, e.dv);
        end
      end
      if (pos >= 2) begin
        checks++;
        if (busa.led !== 5'(av + 5)) begin
          failures++;
          $display("FAIL switch_led cyc=%0d got %0d required %0d", c, busa.led, av + 5);
        end
      end
      if (c == 8) busa.s1 = 4'd9;
    end
  endtask

  task automatic test_max_sum();
    exp_t e;
    reset_a(4'd15, 4'd15);
    for (int c = 0; c < PA; c++) begin
      @(posedge clk); #1;
      e = frame_model(c, DA, BA, 4'd15, 4'd15);
      if (e.dchk) begin
        checks++;
        if (busa.dig_val !== 4'd15) begin
          failures++;
          $display("FAIL max_dig cyc=%0d got %0d required 15", c, busa.dig_val);
        end
      end
      if (c >= 2) begin
        checks++;
        if (busa.led !== 5'd30) begin
          failures++;
          $display("FAIL max_led cyc=%0d got %0d required 30", c, busa.led);
        end
      end
    end
  endtask

  // BLANK=0, DWELL=3: 7-cycle frames, random switches every cycle.
  task automatic test_no_blank();
    exp_t       e;
    logic [3:0] d1, d2, av, bv;
    int         pos;
    d1 = 4'($urandom); d2 = 4'($urandom);
    rb = 1'b1; busb.s1 = d1; busb.s2 = d2;
    @(posedge clk); @(posedge clk); #1;
    rb = 1'b0;
    av = 4'd0; bv = 4'd0;
    for (int c = 0; c < 4*PB; c++) begin
      @(posedge clk); #1;
      pos = c % PB;
      if (pos == 0) begin av = d1; bv = d2; end
      e = frame_model(pos, DB, BB, av, bv);
      checks++;
      if ({busb.frame_tick, busb.en0_n, busb.en1_n} !== {e.tick, e.e0, e.e1}) begin
        failures++;
        $display("FAIL noblank_ctrl cyc=%0d got tick,en0,en1=%b%b%b required %b%b%b",
                 c, busb.frame_tick, busb.en0_n, busb.en1_n, e.tick, e.e0, e.e1);
      end
      if (e.dchk) begin
        checks++;
        if (busb.dig_val !== e.dv) begin
          failures++;
          $display("FAIL noblank_dig cyc=%0d got %0d required %0d", c, busb.dig_val, e.dv);
        end
      end
      if (pos >= 2) begin
        checks++;
        if (busb.led !== 5'({1'b0, av} + {1'b0, bv})) begin
          failures++;
          $display("FAIL noblank_led cyc=%0d got %0d required %0d", c, busb.led, av + bv);
        end
      end
      d1 = 4'($urandom); d2 = 4'($urandom);
      busb.s1 = d1; busb.s2 = d2;
    end
  endtask

  // Reset during the 2nd SHOW1 cycle (cycle 8), then a clean restart.
  task automatic test_reset_mid_frame();
    exp_t e;
    reset_a(4'd3, 4'd5);
    for (int c = 0; c <= 8; c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (busa.en1_n !== 1'b0) begin
      failures++;
      $display("FAIL midrst_pre got en1_n=%b required 0", busa.en1_n);
    end
    ra = 1'b1;
    busa.s1 = 4'd7; busa.s2 = 4'd12;
    @(posedge clk); #1;
    checks++;
    if ({busa.en0_n, busa.en1_n, busa.led, busa.add_a, busa.add_b, busa.frame_tick} !== {1'b1, 1'b1, 5'd0, 4'd0, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL midrst_state got en=%b%b led=%0d a=%0d b=%0d tick=%b required 11 0 0 0 0",
               busa.en0_n, busa.en1_n, busa.led, busa.add_a, busa.add_b, busa.frame_tick);
    end
    ra = 1'b0;
    for (int c = 0; c <= PA; c++) begin
      @(posedge clk); #1;
      e = frame_model(c % PA, DA, BA, 4'd7, 4'd12);
      checks++;
      if ({busa.frame_tick, busa.en0_n, busa.en1_n} !== {e.tick, e.e0, e.e1}) begin
        failures++;
        $display("FAIL midrst_ctrl cyc=%0d got tick,en0,en1=%b%b%b required %b%b%b",
                 c, busa.frame_tick, busa.en0_n, busa.en1_n, e.tick, e.e0, e.e1);
      end
      checks++;
      if (busa.add_a !== 4'd7 || busa.add_b !== 4'd12) begin
        failures++;
        $display("FAIL midrst_ops cyc=%0d got %0d,%0d required 7,12", c, busa.add_a, busa.add_b);
      end
      if (c >= 2 && c < PA) begin
        checks++;
        if (busa.led !== 5'd19) begin
          failures++;
          $display("FAIL midrst_led cyc=%0d got %0d required 19", c, busa.led);
        end
      end
    end
  endtask

  // 1000 frames, switches randomised every cycle.
  task automatic test_long_run();
    exp_t       e;
    logic [3:0] d1, d2, av, bv;
    int         pos;
    d1 = 4'($urandom); d2 = 4'($urandom);
    reset_a(d1, d2);
    av = 4'd0; bv = 4'd0;
    for (int c = 0; c < 1000*PA; c++) begin
      @(posedge clk); #1;
      pos = c % PA;
      if (pos == 0) begin av = d1; bv = d2; end
      e = frame_model(pos, DA, BA, av, bv);
      checks++;
      if ({busa.frame_tick, busa.en0_n, busa.en1_n} !== {e.tick, e.e0, e.e1}) begin
        failures++;
        $display("FAIL long_ctrl cyc=%0d got tick,en0,en1=%b%b%b required %b%b%b",
                 c, busa.frame_tick, busa.en0_n, busa.en1_n, e.tick, e.e0, e.e1);
      end
      checks++;
      if (busa.add_a !== av || busa.add_b !== bv) begin
        failures++;
        $display("FAIL long_ops cyc=%0d got %0d,%0d required %0d,%0d", c, busa.add_a, busa.add_b, av, bv);
      end
      if (e.dchk) begin
        checks++;
        if (busa.dig_val !== e.dv) begin
          failures++;
          $display("FAIL long_dig cyc=%0d got %0d required %0d", c, busa.dig_val, e.dv);
        end
      end
      if (pos >= 2) begin
        checks++;
        if (busa.led !== 5'({1'b0, av} + {1'b0, bv})) begin
          failures++;
          $display("FAIL long_led cyc=%0d got %0d required %0d", c, busa.led, av + bv);
        end
      end
      d1 = 4'($urandom); d2 = 4'($urandom);
      busa.s1 = d1; busa.s2 = d2;
    end
  endtask

  initial begin
    busa.s1 = 4'd0; busa.s2 = 4'd0;
    busb.s1 = 4'd0; busb.s2 = 4'd0;
    test_reset();
    test_basic_frame();
    test_switch_change();
    test_max_sum();
    test_no_blank();
    test_reset_mid_frame();
    test_long_run();
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_mux_controller.md
Name: display_mux_controller

Overview:
- Sequencer that drives one shared 4-bit adder and one shared seven-segment decoder for a two-digit common-anode display.
- Once per frame it snapshots the two switch banks and presents them to the adder as operands.
- It then time-multiplexes digit 0 (operand A) and digit 1 (operand B), with blanking gaps between digits to suppress ghosting.
- It latches the 5-bit adder result onto the LEDs once per frame.

Parameters:
- DWELL_CYCLES, 24000, clock cycles each digit is enabled per frame; must be >= 1.
- BLANK_CYCLES, 240, clock cycles both digits are off between digits; 0 is legal and removes the blank states.
- CNT_W, $clog2(max(DWELL_CYCLES,BLANK_CYCLES,2)), dwell/blank counter width (derived).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- s1  input  4  switch bank 1 (operand A source)
- s2  input  4  switch bank 2 (operand B source)
- sum_in  input  5  combinational sum returned from the adder (add_a + add_b)
- add_a  output  4  registered adder operand A (snapshot of s1)
- add_b  output  4  registered adder operand B (snapshot of s2)
- dig_val  output  4  nibble to the shared seven-segment decoder
- en0_n  output  1  digit 0 anode enable, active-low
- en1_n  output  1  digit 1 anode enable, active-low
- led  output  5  registered sum display
- frame_tick  output  1  one-cycle pulse marking the start of each frame

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset. All outputs are registered.
- Reset values, applied on any clk edge with reset=1 (including mid-frame):
  - state=LOAD, cnt=0
  - add_a=0, add_b=0, dig_val=0, led=0
  - en0_n=1, en1_n=1, frame_tick=0
- States: LOAD -> SHOW0 -> BLANK01 -> SHOW1 -> BLANK10 -> LOAD.
- LOAD, 1 cycle, first cycle after reset deasserts:
  - add_a<=s1, add_b<=s2, frame_tick=1
  - both enables off, cnt<=0
- SHOW0, DWELL_CYCLES cycles:
  - en0_n=0, en1_n=1, dig_val=add_a.
  - On the cycle with cnt==0, led<=sum_in. The new value is visible from the 2nd SHOW0 cycle.
  - Then go to BLANK01, or to SHOW1 if BLANK_CYCLES==0.
- BLANK01, BLANK_CYCLES cycles:
  - en0_n=en1_n=1; dig_val holds its last value.
- SHOW1, DWELL_CYCLES cycles:
  - en1_n=0, en0_n=1, dig_val=add_b.
  - Then go to BLANK10, or to LOAD if BLANK_CYCLES==0.
- BLANK10: same as BLANK01, then go to LOAD.
- Counter: cnt resets to 0 on every state entry and increments each cycle. The state exits on the cycle where cnt==N-1.
- Frame period: exactly 1 + 2*DWELL_CYCLES + 2*BLANK_CYCLES cycles, with frame_tick spaced by the same amount.
- Enable exclusivity: en0_n and en1_n are never both 0 in any cycle, including the transition cycles and the cycle after reset.
- Timing of enables vs dig_val: dig_val is updated on the same edge that asserts the corresponding enable. No cycle shows one digit's value on the other digit.
- Operand stability: changes on s1/s2 outside LOAD are ignored until the next LOAD. add_a/add_b, and therefore sum_in, are constant for the whole frame.
- Arithmetic: the block performs no addition. led is a straight 5-bit copy of sum_in; the max value 15+15=30 (5'b11110) must pass unmodified.
- Reset mid-frame: abandon the frame; the first post-reset cycle is LOAD with a fresh snapshot. The led value from before reset is not retained.

Test Plan:
- Reset release, DWELL=4/BLANK=2, s1=3, s2=5, sum_in modelled as add_a+add_b:
  - LOAD on cycle 0, frame_tick=1, add_a=3, add_b=5
  - cycles 1-4: en0_n=0, dig_val=3; led=8 from cycle 2
  - cycles 5-6: both off
  - cycles 7-10: en1_n=0, dig_val=5
  - cycles 11-12: both off
  - next frame_tick at cycle 13
- Switch change mid-frame: s1 3->9 during SHOW1 of frame 1 -> add_a stays 3 until frame 2 LOAD. Frame 2: dig_val=9 in SHOW0, led=14.
- Max sum: s1=15, s2=15 -> led=5'd30; digits show 15 and 15.
- BLANK_CYCLES=0, DWELL=3: SHOW0->SHOW1->LOAD directly; frame period 7 cycles. Exclusivity assertion holds on every edge.
- Reset asserted on the 2nd SHOW1 cycle:
  - next edge: en0_n=en1_n=1, led=0, add_a=add_b=0
  - deassert: LOAD with a new snapshot
  - frame timing restarts from cycle 0
- Long run of 1000 frames with random s1/s2 changing every cycle:
  - frame_tick period is constant
  - led always equals add_a+add_b of the current frame from the 2nd SHOW0 cycle onward
  - en0_n&en1_n never both 0
